// File: rtl/sram_like_arbiter_if.sv
// sram_like_arbiter_if: sram-like request/response bundle shared by the inst, data and memory ports
interface sram_like_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;
  modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: round-robin sharing of one sram-like memory port between inst and data masters
module sram_like_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                 clk,
  input logic                 resetn,
  sram_like_arbiter_if.slave  inst,
  sram_like_arbiter_if.slave  data,
  sram_like_arbiter_if.master mem
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t            state, state_nx;
  logic              owner, last, arb, grant, winner;
  logic              lat_wr;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  assign arb    = state == IDLE || (state == DATA && mem.data_ok);
  assign grant  = arb && (inst.req || data.req);
  assign winner = (inst.req && data.req) ? ~last : data.req;
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  // next state: hold ADDR until accepted, hold DATA until response, otherwise follow the arbiter
  always_comb
    state_nx = state == ADDR ? (mem.addr_ok ? DATA : ADDR)
             : (state == DATA && !mem.data_ok) ? DATA
             : grant ? ADDR : IDLE;
  // capture the winner and its request fields so the memory side stays stable until accepted
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      owner     <= 1'b0;
      last      <= 1'b0;
      lat_wr    <= 1'b0;
      lat_size  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (grant) begin
      owner     <= winner;
      last      <= winner;
      lat_wr    <= winner ? data.wr    : inst.wr;
      lat_size  <= winner ? data.size  : inst.size;
      lat_addr  <= winner ? data.addr  : inst.addr;
      lat_wdata <= winner ? data.wdata : inst.wdata;
    end
  // outputs: handshakes forwarded only to the owner and only in the matching phase
  always_comb begin
    mem.req      = state == ADDR;
    mem.wr       = lat_wr;
    mem.size     = lat_size;
    mem.addr     = lat_addr;
    mem.wdata    = lat_wdata;
    inst.addr_ok = state == ADDR && !owner && mem.addr_ok;
    data.addr_ok = state == ADDR &&  owner && mem.addr_ok;
    inst.data_ok = state == DATA && !owner && mem.data_ok;
    data.data_ok = state == DATA &&  owner && mem.data_ok;
    inst.rdata   = mem.rdata;
    data.rdata   = mem.rdata;
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed and randomized checks against a transaction-level model
module tb_sram_like_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  sram_like_arbiter_if inst_bus ();
  sram_like_arbiter_if data_bus ();
  sram_like_arbiter_if mem_bus ();
  sram_like_arbiter dut (
    .clk    (clk),
    .resetn (resetn),
    .inst   (inst_bus),
    .data   (data_bus),
    .mem    (mem_bus)
  );
  always #5 clk = ~clk;
  bit          m_busy, m_acc, m_own, m_last, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  int          gq[$];
  task automatic check(string tag, logic [127:0] obs, logic [127:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask
  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_own = 0; m_last = 0;
    m_wr = 0; m_size = '0; m_addr = '0; m_wdata = '0;
  endtask
  task automatic model_update();
    bit ir, dr, w;
    if (!resetn) begin
      model_reset();
      return;
    end
    ir = inst_bus.req;
    dr = data_bus.req;
    if (!m_busy || (m_acc && mem_bus.data_ok)) begin
      m_busy = ir || dr;
      m_acc  = 0;
      if (m_busy) begin
        w       = (ir && dr) ? !m_last : dr;
        m_own   = w;
        m_last  = w;
        m_wr    = w ? data_bus.wr    : inst_bus.wr;
        m_size  = w ? data_bus.size  : inst_bus.size;
        m_addr  = w ? data_bus.addr  : inst_bus.addr;
        m_wdata = w ? data_bus.wdata : inst_bus.wdata;
      end
    end else if (!m_acc && mem_bus.addr_ok) m_acc = 1;
  endtask
  task automatic compare();
    bit er, eia, eda, eid, edd;
    er  = m_busy && !m_acc;
    eia = er && !m_own && mem_bus.addr_ok;
    eda = er &&  m_own && mem_bus.addr_ok;
    eid = m_busy && m_acc && !m_own && mem_bus.data_ok;
    edd = m_busy && m_acc &&  m_own && mem_bus.data_ok;
    check("ctrl", {mem_bus.req, inst_bus.addr_ok, inst_bus.data_ok, data_bus.addr_ok, data_bus.data_ok},
          {er, eia, eid, eda, edd});
    if (er) check("mem_fields", {mem_bus.wr, mem_bus.size, mem_bus.addr, mem_bus.wdata},
                  {m_wr, m_size, m_addr, m_wdata});
    check("rdata", {inst_bus.rdata, data_bus.rdata}, {mem_bus.rdata, mem_bus.rdata});
    if (data_bus.addr_ok) gq.push_back(1);
    if (inst_bus.addr_ok) gq.push_back(0);
  endtask
  task automatic settle();
    #1;
    compare();
  endtask
  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask
  task automatic idle_inputs();
    inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = 2'd2; inst_bus.addr = '0; inst_bus.wdata = '0;
    data_bus.req = 0; data_bus.wr = 0; data_bus.size = 2'd2; data_bus.addr = '0; data_bus.wdata = '0;
    mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = '0;
  endtask
  task automatic rand_inputs();
    inst_bus.req = $urandom_range(0, 9) < 6; inst_bus.wr = $urandom_range(0, 7) == 0;
    inst_bus.size = 2'($urandom_range(0, 2)); inst_bus.addr = $urandom; inst_bus.wdata = $urandom;
    data_bus.req = $urandom_range(0, 9) < 6; data_bus.wr = 1'($urandom);
    data_bus.size = 2'($urandom_range(0, 2)); data_bus.addr = $urandom; data_bus.wdata = $urandom;
    mem_bus.addr_ok = 1'($urandom); mem_bus.data_ok = 1'($urandom); mem_bus.rdata = $urandom;
  endtask
  task automatic set_reset(bit v);
    resetn = v;
    if (!v) model_reset();
  endtask
  task automatic do_reset();
    set_reset(0);
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      settle();
      check("rst_ctrl", {mem_bus.req, inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok}, 5'b0);
      advance();
    end
    idle_inputs();
    resetn = 1;
    settle();
    advance();
  endtask
  initial begin
    model_reset();
    idle_inputs();
    @(negedge clk);
    do_reset();
    // single inst read
    inst_bus.req = 1; inst_bus.addr = 32'hBFC00000;
    settle(); check("t0_mem_req", mem_bus.req, 0); advance();
    mem_bus.addr_ok = 1;
    settle();
    check("t1_mem_req", mem_bus.req, 1);
    check("t1_mem_addr", mem_bus.addr, 32'hBFC00000);
    check("t1_mem_wr", mem_bus.wr, 0);
    check("t1_inst_addr_ok", inst_bus.addr_ok, 1);
    check("t1_data_addr_ok", data_bus.addr_ok, 0);
    advance();
    inst_bus.req = 0; mem_bus.addr_ok = 0;
    settle(); check("t2_inst_data_ok", inst_bus.data_ok, 0); advance();
    mem_bus.data_ok = 1; mem_bus.rdata = 32'h3C1D0001;
    settle();
    check("t3_inst_data_ok", inst_bus.data_ok, 1);
    check("t3_inst_rdata", inst_bus.rdata, 32'h3C1D0001);
    check("t3_data_data_ok", data_bus.data_ok, 0);
    advance();
    mem_bus.data_ok = 0;
    // simultaneous requests after reset: data first
    do_reset();
    data_bus.req = 1; data_bus.wr = 1; data_bus.size = 2; data_bus.addr = 32'h80000010; data_bus.wdata = 32'h00001234;
    inst_bus.req = 1; inst_bus.addr = 32'hBFC00004;
    settle(); advance();
    mem_bus.addr_ok = 1;
    settle();
    check("sim_mem_wr", mem_bus.wr, 1);
    check("sim_mem_wdata", mem_bus.wdata, 32'h00001234);
    check("sim_mem_addr", mem_bus.addr, 32'h80000010);
    check("sim_data_addr_ok", data_bus.addr_ok, 1);
    check("sim_inst_addr_ok", inst_bus.addr_ok, 0);
    advance();
    data_bus.req = 0; mem_bus.addr_ok = 0; mem_bus.data_ok = 1;
    settle(); check("sim_data_data_ok", data_bus.data_ok, 1); advance();
    mem_bus.data_ok = 0;
    settle();
    check("sim_inst_mem_req", mem_bus.req, 1);
    check("sim_inst_mem_addr", mem_bus.addr, 32'hBFC00004);
    check("sim_inst_mem_wr", mem_bus.wr, 0);
    mem_bus.addr_ok = 1;
    settle(); advance();
    inst_bus.req = 0; mem_bus.addr_ok = 0; mem_bus.data_ok = 1;
    settle(); advance();
    idle_inputs();
    // stalled acceptance with the master changing its address
    inst_bus.req = 1; inst_bus.addr = 32'hBFC00008;
    settle(); advance();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) inst_bus.addr = 32'hBFC0000C;
      settle();
      check("stall_mem_req", mem_bus.req, 1);
      check("stall_mem_addr", mem_bus.addr, 32'hBFC00008);
      check("stall_inst_addr_ok", inst_bus.addr_ok, 0);
      advance();
    end
    mem_bus.addr_ok = 1;
    settle();
    check("stall_acc_addr_ok", inst_bus.addr_ok, 1);
    check("stall_acc_addr", mem_bus.addr, 32'hBFC00008);
    advance();
    inst_bus.req = 0; mem_bus.addr_ok = 0; mem_bus.data_ok = 1;
    settle(); advance();
    idle_inputs();
    // continuous contention with single-cycle memory
    do_reset();
    gq.delete();
    inst_bus.req = 1; data_bus.req = 1; mem_bus.addr_ok = 1; mem_bus.data_ok = 1;
    for (int c = 0; c < 40 && gq.size() < 8; c++) begin
      settle(); advance();
    end
    if (gq.size() < 8) check("contention_timeout", gq.size(), 8);
    else for (int i = 0; i < 8; i++) check("grant_order", gq[i], (i % 2 == 0) ? 1 : 0);
    idle_inputs();
    settle(); advance();
    settle(); advance();
    // reset asserted during DATA, then a stray response
    do_reset();
    inst_bus.req = 1; inst_bus.addr = 32'hBFC00010;
    settle(); advance();
    mem_bus.addr_ok = 1;
    settle(); advance();
    inst_bus.req = 0; mem_bus.addr_ok = 0; mem_bus.data_ok = 1;
    settle();
    check("pre_rst_inst_data_ok", inst_bus.data_ok, 1);
    set_reset(0);
    #1;
    check("async_rst_ctrl", {mem_bus.req, inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok}, 5'b0);
    advance();
    resetn = 1;
    mem_bus.data_ok = 1;
    settle();
    check("stray_inst_data_ok", inst_bus.data_ok, 0);
    check("stray_data_data_ok", data_bus.data_ok, 0);
    advance();
    idle_inputs();
    // randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      if ($urandom_range(0, 199) == 0) set_reset(0);
      else resetn = 1;
      settle();
      advance();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
